// File: rtl/ts_bus_pkg.sv
// Shared types and bus-phase encodings for the PSG-style two-chip register bus master.
package ts_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE, ST_SEL, ST_SEL_GAP, ST_ADR, ST_ADR_GAP, ST_WR, ST_RD, ST_END_GAP
   } state_t;

   // {BDIR, BC}
   localparam logic [1:0] PH_ADDR  = 2'b11;
   localparam logic [1:0] PH_WRITE = 2'b10;
   localparam logic [1:0] PH_READ  = 2'b01;
   localparam logic [1:0] PH_IDLE  = 2'b00;

   localparam logic [4:0] SEL_PREFIX = 5'b11111;

   typedef struct packed {
      logic       wr;
      logic       chip;
      logic       fm_ena;
      logic       stat_sel;
      logic [7:0] addr;
      logic [7:0] data;
   } req_t;

   // FM enable is active-low on the wire.
   function automatic logic [7:0] sel_cmd(input logic chip, input logic fm_ena,
                                          input logic stat_sel);
      return {SEL_PREFIX, ~fm_ena, stat_sel, chip};
   endfunction

endpackage

// File: rtl/ts_bus_master_if.sv
// Request/response handshake plus PSG bus pins of the bus master.
interface ts_bus_master_if;
   logic       REQ_VALID;
   logic       REQ_READY;
   logic       REQ_WR;
   logic       REQ_CHIP;
   logic       REQ_FM_ENA;
   logic       REQ_STAT_SEL;
   logic [7:0] REQ_ADDR;
   logic [7:0] REQ_DATA;
   logic       RSP_VALID;
   logic       RSP_ERR;
   logic [7:0] RSP_DATA;
   logic       BDIR;
   logic       BC;
   logic [7:0] DO;
   logic [7:0] DI;

   modport master (
      input  REQ_VALID, REQ_WR, REQ_CHIP, REQ_FM_ENA, REQ_STAT_SEL, REQ_ADDR, REQ_DATA, DI,
      output REQ_READY, RSP_VALID, RSP_ERR, RSP_DATA, BDIR, BC, DO
   );

   modport slave (
      output REQ_VALID, REQ_WR, REQ_CHIP, REQ_FM_ENA, REQ_STAT_SEL, REQ_ADDR, REQ_DATA, DI,
      input  REQ_READY, RSP_VALID, RSP_ERR, RSP_DATA, BDIR, BC, DO
   );
endinterface

// File: rtl/ts_bus_master.sv
// Sequences select/address/data phases on a BDIR/BC bus; select is skipped when the
// cached chip configuration already matches the request.
module ts_bus_master
   import ts_bus_pkg::*;
#(
   parameter int HOLD_CYC = 4,
   parameter int GAP_CYC  = 2
) (
   input logic              CLK,
   input logic              RESET,
   ts_bus_master_if.master  bus
);

   localparam logic [3:0] HOLD_LD = 4'(HOLD_CYC - 1);
   localparam logic [3:0] GAP_LD  = 4'(GAP_CYC - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   req_t       req_q, req_nxt, req_in;
   logic       cache_vld, cache_vld_nxt;
   logic [2:0] cache_cfg, cache_cfg_nxt, cfg_in;
   logic [1:0] ph_q, ph_nxt;
   logic [7:0] do_q, do_nxt;
   logic       rsp_valid_q, rsp_valid_nxt;
   logic       rsp_err_q, rsp_err_nxt;
   logic [7:0] rsp_data_q, rsp_data_nxt;
   logic       accept, done;

   assign bus.REQ_READY = (state == ST_IDLE) && !RESET;
   assign accept        = bus.REQ_VALID && bus.REQ_READY;
   assign req_in        = {bus.REQ_WR, bus.REQ_CHIP, bus.REQ_FM_ENA, bus.REQ_STAT_SEL,
                           bus.REQ_ADDR, bus.REQ_DATA};
   assign cfg_in        = {bus.REQ_CHIP, bus.REQ_FM_ENA, bus.REQ_STAT_SEL};
   assign done          = (cnt == 4'd0);

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = (state != ST_IDLE && !done) ? cnt - 4'd1 : cnt;
      req_nxt       = req_q;
      cache_vld_nxt = cache_vld;
      cache_cfg_nxt = cache_cfg;
      rsp_valid_nxt = 1'b0;
      rsp_err_nxt   = 1'b0;
      rsp_data_nxt  = rsp_data_q;
      case (state)
         ST_IDLE: if (accept) begin
            req_nxt = req_in;
            if (req_in.addr[7:3] == SEL_PREFIX) begin
               // Address range collides with the select command: refuse without touching the bus.
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = 1'b1;
            end else begin
               cnt_nxt = HOLD_LD;
               if (!cache_vld || cache_cfg != cfg_in) begin
                  state_nxt     = ST_SEL;
                  cache_vld_nxt = 1'b1;
                  cache_cfg_nxt = cfg_in;
               end else begin
                  state_nxt = ST_ADR;
               end
            end
         end
         ST_SEL:     if (done) begin state_nxt = ST_SEL_GAP; cnt_nxt = GAP_LD;  end
         ST_SEL_GAP: if (done) begin state_nxt = ST_ADR;     cnt_nxt = HOLD_LD; end
         ST_ADR:     if (done) begin state_nxt = ST_ADR_GAP; cnt_nxt = GAP_LD;  end
         ST_ADR_GAP: if (done) begin
            state_nxt = req_q.wr ? ST_WR : ST_RD;
            cnt_nxt   = HOLD_LD;
         end
         ST_WR:      if (done) begin state_nxt = ST_END_GAP; cnt_nxt = GAP_LD;  end
         ST_RD:      if (done) begin
            state_nxt    = ST_END_GAP;
            cnt_nxt      = GAP_LD;
            rsp_data_nxt = bus.DI;
         end
         ST_END_GAP: if (done) begin state_nxt = ST_IDLE; rsp_valid_nxt = 1'b1; end
         default:    state_nxt = ST_IDLE;
      endcase

      // Bus pins are decoded from the next state so they change on the same edge as the state.
      ph_nxt = PH_IDLE;
      do_nxt = 8'h00;
      case (state_nxt)
         ST_SEL: begin
            ph_nxt = PH_ADDR;
            do_nxt = sel_cmd(req_nxt.chip, req_nxt.fm_ena, req_nxt.stat_sel);
         end
         ST_ADR:  begin ph_nxt = PH_ADDR;  do_nxt = req_nxt.addr; end
         ST_WR:   begin ph_nxt = PH_WRITE; do_nxt = req_nxt.data; end
         ST_RD:   ph_nxt = PH_READ;
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= ST_IDLE;
         cnt         <= 4'd0;
         req_q       <= '0;
         cache_vld   <= 1'b0;
         cache_cfg   <= 3'd0;
         ph_q        <= PH_IDLE;
         do_q        <= 8'h00;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= 8'h00;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         req_q       <= req_nxt;
         cache_vld   <= cache_vld_nxt;
         cache_cfg   <= cache_cfg_nxt;
         ph_q        <= ph_nxt;
         do_q        <= do_nxt;
         rsp_valid_q <= rsp_valid_nxt;
         rsp_err_q   <= rsp_err_nxt;
         rsp_data_q  <= rsp_data_nxt;
      end
   end

   assign bus.BDIR      = ph_q[1];
   assign bus.BC        = ph_q[0];
   assign bus.DO        = do_q;
   assign bus.RSP_VALID = rsp_valid_q;
   assign bus.RSP_ERR   = rsp_err_q;
   assign bus.RSP_DATA  = rsp_data_q;

endmodule
